// File: rtl/text_pkg.sv
// ------------------------------------------------------------------------
// text_pkg : text-mode screen geometry, fetch state type and VRAM address helper.
// Revision : 1.0
// ------------------------------------------------------------------------
`default_nettype none

package text_pkg;

  localparam int COLS          = 80;
  localparam int ROWS          = 30;
  localparam int WORDS_PER_ROW = 40;

  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] H_TOTAL   = 10'd800;
  localparam logic [9:0] V_TOTAL   = 10'd525;
  localparam logic [9:0] PRELOAD_X = 10'd784;

  typedef enum logic [1:0] {BLANK, PRELOAD, ACTIVE} fetch_state_t;

  // row*40 + word, built from shifts so no multiplier is inferred
  function automatic logic [10:0] word_addr(input logic [4:0] row, input logic [5:0] word);
    logic [10:0] r;
    r = {6'd0, row};
    return (r << 5) + (r << 3) + {5'd0, word};
  endfunction

endpackage

`default_nettype wire

// File: rtl/text_fetch_if.sv
// ------------------------------------------------------------------------
// text_fetch_if : VRAM read port between the text fetch stage and the VRAM.
// Revision      : 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface text_fetch_if #(
  parameter int ADDR_W = 11
);

  logic              vram_rd_en;
  logic [ADDR_W-1:0] vram_addr;
  logic [31:0]       vram_rd_data;

  modport master (
    output vram_rd_en,
    output vram_addr,
    input  vram_rd_data
  );

  modport slave (
    input  vram_rd_en,
    input  vram_addr,
    output vram_rd_data
  );

endinterface

`default_nettype wire

// File: rtl/text_fetch.sv
// ------------------------------------------------------------------------
// text_fetch : prefetches packed character words from VRAM ahead of the beam.
// Revision   : 1.0
// ------------------------------------------------------------------------
`default_nettype none

module text_fetch
  import text_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  text_fetch_if.master     vram,
  output logic [15:0]      draw_code,
  output logic [9:0]       DrawX_d,
  output logic [9:0]       DrawY_d
);

  localparam logic [3:0] LAT_LAST  = 4'(RD_LAT);
  localparam logic [5:0] WORDS_END = 6'(WORDS_PER_ROW);

  fetch_state_t      state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       cur_word_q, cur_word_d;
  logic [31:0]       next_word_q, next_word_d;
  logic [4:0]        row_q, row_d;
  logic [5:0]        word_q, word_d;
  logic [3:0]        lat_q, lat_d;
  logic [15:0]       code_q, code_d;
  logic [9:0]        xd_q, yd_q;
  logic [9:0]        next_y;
  logic              last_of_word;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= BLANK;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      cur_word_q  <= '0;
      next_word_q <= '0;
      row_q       <= '0;
      word_q      <= '0;
      lat_q       <= '0;
      code_q      <= '0;
      xd_q        <= '0;
      yd_q        <= '0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      cur_word_q  <= cur_word_d;
      next_word_q <= next_word_d;
      row_q       <= row_d;
      word_q      <= word_d;
      lat_q       <= lat_d;
      code_q      <= code_d;
      xd_q        <= DrawX;
      yd_q        <= DrawY;
    end
  end

  // Read strobes are registered one pixel early so the strobe is high
  // while DrawX equals the issue column (784 for preload, 16w in-line).
  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    addr_d       = addr_q;
    cur_word_d   = cur_word_q;
    next_word_d  = next_word_q;
    row_d        = row_q;
    word_d       = word_q;
    lat_d        = lat_q;
    next_y       = (DrawY == V_TOTAL - 10'd1) ? 10'd0 : DrawY + 10'd1;
    last_of_word = (DrawX[3:0] == 4'hF) && (DrawX < H_VIS);

    unique case (state_q)
      BLANK: begin
        if (DrawX == PRELOAD_X - 10'd1 && next_y < V_VIS) begin
          rd_en_d = 1'b1;
          addr_d  = ADDR_W'(word_addr(next_y[8:4], 6'd0));
          row_d   = next_y[8:4];
          word_d  = 6'd1;
          lat_d   = 4'd0;
          state_d = PRELOAD;
        end
      end
      PRELOAD: begin
        lat_d = lat_q + 4'd1;
        if (lat_q == LAT_LAST) begin
          cur_word_d = vram.vram_rd_data;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        // Word 1 is requested from the last pixel of the preceding line
        if ((DrawX == H_TOTAL - 10'd1 || last_of_word) && word_q < WORDS_END) begin
          rd_en_d = 1'b1;
          addr_d  = ADDR_W'(word_addr(row_q, word_q));
          word_d  = word_q + 6'd1;
        end
        if (DrawX[3:0] == LAT_LAST && DrawX < H_VIS - 10'd16) begin
          next_word_d = vram.vram_rd_data;
        end
        if (last_of_word) begin
          cur_word_d = next_word_q;
        end
        if (DrawX == H_VIS - 10'd1) begin
          state_d = BLANK;
        end
      end
      default: state_d = BLANK;
    endcase

    if (DrawX < H_VIS && DrawY < V_VIS) begin
      code_d = DrawX[3] ? cur_word_q[31:16] : cur_word_q[15:0];
    end else begin
      code_d = 16'h0000;
    end
  end

  assign vram.vram_rd_en = rd_en_q;
  assign vram.vram_addr  = addr_q;
  assign draw_code       = code_q;
  assign DrawX_d         = xd_q;
  assign DrawY_d         = yd_q;

endmodule

`default_nettype wire

// File: tb/tb_text_fetch.sv
// ------------------------------------------------------------------------
// tb_text_fetch : directed line sequence with random VRAM contents and a pixel-level model.
// Revision      : 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_text_fetch;

  logic        Clk;
  logic        Reset;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [15:0] draw_code;
  logic [9:0]  DrawX_d;
  logic [9:0]  DrawY_d;

  text_fetch_if #(.ADDR_W(11)) vif ();

  text_fetch #(.ADDR_W(11), .RD_LAT(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .vram      (vif),
    .draw_code (draw_code),
    .DrawX_d   (DrawX_d),
    .DrawY_d   (DrawY_d)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // VRAM model: two-cycle read latency, undefined data when nothing was read
  logic [31:0] mem [0:2047];
  logic [31:0] pipe1;
  always @(posedge Clk) begin
    pipe1 <= vif.vram_rd_en ? mem[vif.vram_addr] : 32'hxxxx_xxxx;
    vif.vram_rd_data <= pipe1;
  end

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int obs_reads   = 0;
  int exp_reads   = 0;
  int max_addr    = 0;
  int cur_x, cur_y;

  // Model of what the fetch stage holds for the line being drawn
  bit pend_valid = 0;
  int pend_row   = 0;
  bit line_valid = 0;
  int line_row   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s x=%0d y=%0d observed=%h expected=%h", tag, cur_x, cur_y, obs, exp);
    end
  endtask

  task automatic randomize_mem();
    for (int k = 0; k < 2048; k++) mem[k] = $urandom;
    mem[0] = 32'h8041_0048;
  endtask

  task automatic run_cycle(input int x, input int y);
    int          ny;
    int          a;
    bit          exp_rd;
    int          exp_addr;
    logic [15:0] exp_code;
    logic [31:0] w;

    if (cyc == 20) Reset = 1'b1;
    cyc++;
    cur_x = x;
    cur_y = y;
    DrawX = 10'(x);
    DrawY = 10'(y);

    if (x == 0) begin
      line_valid = pend_valid;
      line_row   = pend_row;
      pend_valid = 0;
    end
    if (!Reset) begin
      line_valid = 0;
      pend_valid = 0;
    end

    exp_rd   = 0;
    exp_addr = 0;
    if (Reset) begin
      if (x == 784) begin
        ny = (y == 524) ? 0 : y + 1;
        pend_valid = (ny < 480);
        pend_row   = ny / 16;
        if (ny < 480) begin
          exp_rd   = 1;
          exp_addr = (ny / 16) * 40;
        end
      end else if (line_valid && x <= 608 && x % 16 == 0) begin
        exp_rd   = 1;
        exp_addr = line_row * 40 + x / 16 + 1;
      end
    end
    if (exp_rd) exp_reads++;
    if (vif.vram_rd_en === 1'b1) begin
      obs_reads++;
      if (int'(vif.vram_addr) > max_addr) max_addr = int'(vif.vram_addr);
    end
    chk("rd_en", {31'd0, vif.vram_rd_en}, {31'd0, exp_rd});
    if (exp_rd) chk("vram_addr", {21'd0, vif.vram_addr}, 32'(exp_addr));

    exp_code = 16'h0000;
    if (Reset && line_valid && x < 640 && y < 480) begin
      a = line_row * 40 + x / 16;
      w = mem[a];
      exp_code = ((x / 8) % 2 == 1) ? w[31:16] : w[15:0];
    end

    @(posedge Clk);
    #1;
    chk("draw_code", {16'd0, draw_code}, {16'd0, exp_code});
    chk("DrawX_d", {22'd0, DrawX_d}, Reset ? 32'(x) : 32'd0);
    chk("DrawY_d", {22'd0, DrawY_d}, Reset ? 32'(y) : 32'd0);
    if (Reset && line_valid && y == 0 && x < 16)
      chk("line0_word0", {16'd0, draw_code}, (x >= 8) ? 32'h8041 : 32'h0048);
  endtask

  task automatic run_line(input int y, input int xstart);
    if (y == 500) randomize_mem();
    for (int x = xstart; x < 800; x++) run_cycle(x, y);
  endtask

  int lines [28] = '{11, 12, 15, 16, 17, 100, 101, 463, 464, 478, 479, 480, 500,
                     523, 524, 0, 1, 2, 15, 16, 250, 251, 479, 480, 524, 0, 1, 640 - 600};

  initial begin
    Reset = 1'b0;
    DrawX = 10'd300;
    DrawY = 10'd10;
    randomize_mem();

    // reset held for the first 20 pixels of a mid-frame line, then released
    run_line(10, 300);
    for (int i = 0; i < 28; i++) run_line(lines[i], 0);

    cur_x = -1;
    cur_y = -1;
    chk("read_count", 32'(obs_reads), 32'(exp_reads));
    chk("max_addr", 32'(max_addr), 32'd1199);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/text_fetch.md
# text_fetch

Pixel-rate fetch stage that sits directly upstream of the colour mapper in the text-mode HDMI path. It reads packed character words from the on-chip VRAM read port ahead of the beam. It presents one 16-bit draw_code per pixel, plus DrawX/DrawY delayed by one cycle so the two stay aligned. Screen is 80×30 cells of 8×16 pixels. Each 32-bit VRAM word holds two codes.

## Interface
Parameters:
- ADDR_W, 11, VRAM word-address width (1200 words used)
- RD_LAT, 2, VRAM read latency in Clk cycles (rd_en at t → rd_data valid at t+2)

Ports:
- Clk  in  1  pixel clock; one DrawX step per cycle
- Reset  in  1  asynchronous, active-low reset
- DrawX  in  10  beam column 0..799 (visible 0..639), from VGA controller
- DrawY  in  10  beam row 0..524 (visible 0..479)
- vram_rd_en  out  1  one-cycle read strobe
- vram_addr  out  ADDR_W  word address, valid with vram_rd_en
- vram_rd_data  in  32  word; [15:0] = even column, [31:16] = odd column
- draw_code  out  16  code for pixel (DrawX_d, DrawY_d), to colour mapper
- DrawX_d  out  10  DrawX delayed 1 cycle
- DrawY_d  out  10  DrawY delayed 1 cycle

## Operation
- Addressing:
  - row = DrawY[8:4]
  - word = DrawX[9:4]
  - addr = row·40 + word, computed as (row<<5)+(row<<3)+word, ADDR_W bits, no wrap (max 1199).
- State machine, states BLANK, PRELOAD, ACTIVE.
  - BLANK: no reads issued.
    - At DrawX==784, compute next_y = (DrawY==524) ? 0 : DrawY+1.
    - If next_y<480, issue a read for word 0 of row next_y[8:4] and go to PRELOAD.
  - PRELOAD: capture rd_data into cur_word on the RD_LAT-th cycle after issue, then go to ACTIVE.
  - ACTIVE, per 16-pixel word w (DrawX=16w..16w+15):
    - At DrawX[3:0]==0 and w≤38: issue a read for word w+1.
    - Capture the returned data into next_word at DrawX=16w+2.
    - At DrawX[3:0]==15: cur_word ← next_word.
    - At DrawX==639: go to BLANK. No read is issued for word 40.
- Output register, each cycle:
  - draw_code ← DrawX[3] ? cur_word[31:16] : cur_word[15:0], gated to 0 when DrawX≥640 or DrawY≥480.
  - DrawX_d ← DrawX; DrawY_d ← DrawY.
- vram_rd_en is high for exactly one cycle per issued read. vram_addr holds its last value otherwise.

## Timing
- Latency: draw_code corresponds to DrawX_d/DrawY_d, one cycle after DrawX/DrawY. All three outputs are registered.
- Reads per visible line: exactly 40 (1 preload + 39 in-line). None during vertical blank (next_y 480..524).
- The line-0 preload fires at DrawX==784, DrawY==524.
- Reset values: draw_code=0, DrawX_d=0, DrawY_d=0, vram_rd_en=0, vram_addr=0, cur_word=0, next_word=0, state=BLANK.
- Reset deasserted mid-frame: the block stays in BLANK and outputs code 0 until the next DrawX==784 preload. Correct codes begin on the following visible line.
- DrawX discontinuity (not +1 or wrap 799→0): no recovery logic. The next DrawX==784 preload resynchronises.
- Boundaries:
  - last cell (DrawX 632..639) uses cur_word loaded at DrawX==623
  - row 29 last word addr = 1199
  - next_y wrap 524→0 is handled in BLANK

## Structure
- Package text_pkg holds:
  - constants COLS=80, ROWS=30, WORDS_PER_ROW=40, H_VIS=640, V_VIS=480, H_TOTAL=800, V_TOTAL=525, PRELOAD_X=784
  - typedef enum logic [1:0] {BLANK, PRELOAD, ACTIVE} fetch_state_t
- Shared with the VGA controller and the AXI VRAM writer.
- Single module with no sub-modules. The VRAM itself is instantiated outside, at the top level.

## Test plan
- Reset low mid-line, then release → all outputs 0; vram_rd_en stays 0 until DrawX==784.
- VRAM word 0 = 0x8041_0048, one full line from DrawY=0 → DrawX_d 0..7 give draw_code 0x0048; DrawX_d 8..15 give 0x8041.
- Full frame with VRAM[k]=k → exactly 480×40 reads; addr sequence 0..39 on DrawY 0..15, 40..79 on DrawY 16..31, last read addr 1199.
- Read timing check → read for word w+1 at DrawX==16w; preload at DrawX==784 of the previous line (DrawY 524 for row 0); no reads while next_y≥480.
- Blank region, DrawX 640..799 or DrawY 480..524 → draw_code==0 regardless of VRAM contents.
- VRAM model with RD_LAT=2 and randomised contents over 2 frames → scoreboard matches draw_code for every visible pixel against VRAM[(y>>4)·40+(x>>4)] half selected by x[3].
